// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit CPU: opcode numbering, instruction
// field positions, fetch/decode state encoding and the decoded bundle.
package cpu_pkg;

    localparam logic [4:0] OP_NOP  = 5'd0;
    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_ADC  = 5'd2;
    localparam logic [4:0] OP_SUB  = 5'd3;
    localparam logic [4:0] OP_SDC  = 5'd4;
    localparam logic [4:0] OP_SBB  = 5'd5;
    localparam logic [4:0] OP_AND  = 5'd6;
    localparam logic [4:0] OP_OR   = 5'd7;
    localparam logic [4:0] OP_XOR  = 5'd8;
    localparam logic [4:0] OP_NOT  = 5'd9;
    localparam logic [4:0] OP_SHFT = 5'd10;
    localparam logic [4:0] OP_MOV  = 5'd11;
    localparam logic [4:0] OP_JMP  = 5'd12;
    localparam logic [4:0] OP_JGO  = 5'd13;
    localparam logic [4:0] OP_JLO  = 5'd14;
    localparam logic [4:0] OP_JEO  = 5'd15;
    localparam logic [4:0] OP_HLT  = 5'd16;
    localparam logic [4:0] OP_RST  = 5'd17;
    localparam logic [4:0] OP_SETH = 5'd18;
    localparam logic [4:0] OP_SETL = 5'd19;

    localparam int OPP_MSB = 15;
    localparam int OPP_LSB = 11;
    localparam int R1_MSB  = 10;
    localparam int R1_LSB  = 8;
    localparam int R2_MSB  = 7;
    localparam int R2_LSB  = 5;
    localparam int QR_MSB  = 4;
    localparam int QR_LSB  = 2;
    localparam int RES_MSB = 1;
    localparam int RES_LSB = 0;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT_BR,
        ST_HALT
    } fd_state_t;

    typedef struct packed {
        logic [4:0] opp;
        logic [2:0] r1;
        logic [2:0] r2;
        logic [2:0] qr;
        logic [1:0] res;
        logic [7:0] imm8;
    } dec_t;

    function automatic logic is_jump(input logic [4:0] op);
        return (op >= OP_JMP) && (op <= OP_JEO);
    endfunction

endpackage

// File: rtl/instr_split.sv
// Combinational split of an instruction word into decoded fields;
// reserved opcodes are presented to the control unit as NOP.
module instr_split
    import cpu_pkg::*;
(
    input  logic [15:0] instr,
    output dec_t        fields
);

    always_comb begin
        fields      = '0;
        fields.opp  = instr[OPP_MSB:OPP_LSB];
        fields.r1   = instr[R1_MSB:R1_LSB];
        fields.r2   = instr[R2_MSB:R2_LSB];
        fields.qr   = instr[QR_MSB:QR_LSB];
        fields.res  = instr[RES_MSB:RES_LSB];
        fields.imm8 = instr[IMM_MSB:IMM_LSB];
        if (fields.opp > OP_SETL) begin
            fields.opp = OP_NOP;
        end
    end

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode stage: owns the PC, fetches over a req/ack port and
// issues decoded fields to the control unit with a valid/ready handshake.
module fetch_decode
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_rdata,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [4:0]  opp,
    output logic [2:0]  r1,
    output logic [2:0]  r2,
    output logic [2:0]  qr,
    output logic [1:0]  res,
    output logic [7:0]  imm8,
    input  logic        br_valid,
    input  logic        br_taken,
    input  logic [15:0] br_target,
    output logic [15:0] pc,
    output logic        halted
);

    fd_state_t   state_q, state_d;
    logic [15:0] pc_q, pc_d;
    dec_t        dec_q, dec_d;
    dec_t        split;
    logic        imem_req_q, imem_req_d;
    logic        dec_valid_q, dec_valid_d;
    logic        halted_q, halted_d;

    instr_split u_split (
        .instr  (imem_rdata),
        .fields (split)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_BOOT;
            pc_q        <= RESET_PC;
            dec_q       <= '0;
            imem_req_q  <= 1'b0;
            dec_valid_q <= 1'b0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            dec_q       <= dec_d;
            imem_req_q  <= imem_req_d;
            dec_valid_q <= dec_valid_d;
            halted_q    <= halted_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        dec_d   = dec_q;
        case (state_q)
            ST_BOOT: state_d = ST_FETCH;
            ST_FETCH: begin
                if (imem_req_q && imem_ack) begin
                    dec_d   = split;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (dec_valid_q && dec_ready) begin
                    unique case (1'b1)
                        is_jump(dec_q.opp): state_d = ST_WAIT_BR;
                        dec_q.opp == OP_HLT: state_d = ST_HALT;
                        dec_q.opp == OP_RST: begin
                            pc_d    = RESET_PC;
                            state_d = ST_FETCH;
                        end
                        default: begin
                            pc_d    = pc_q + 16'd1;
                            state_d = ST_FETCH;
                        end
                    endcase
                end
            end
            ST_WAIT_BR: begin
                if (br_valid) begin
                    // JMP redirects regardless of the resolved condition
                    if (br_taken || dec_q.opp == OP_JMP) begin
                        pc_d = br_target;
                    end else begin
                        pc_d = pc_q + 16'd1;
                    end
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_BOOT;
        endcase
    end

    // Outputs are computed from the next state so they leave flops.
    always_comb begin
        imem_req_d  = (state_d == ST_FETCH);
        dec_valid_d = (state_d == ST_ISSUE);
        halted_d    = (state_d == ST_HALT);
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign dec_valid = dec_valid_q;
    assign halted    = halted_q;
    assign opp       = dec_q.opp;
    assign r1        = dec_q.r1;
    assign r2        = dec_q.r2;
    assign qr        = dec_q.qr;
    assign res       = dec_q.res;
    assign imm8      = dec_q.imm8;

endmodule

// File: tb/tb_fetch_decode.sv
// Directed bench for fetch_decode: zero-wait memory model plus a
// scoreboard of expected issues checked at every handshake.
module tb_fetch_decode;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;
    logic        dec_valid;
    logic        dec_ready;
    logic [4:0]  opp;
    logic [2:0]  r1, r2, qr;
    logic [1:0]  res;
    logic [7:0]  imm8;
    logic        br_valid, br_taken;
    logic [15:0] br_target;
    logic [15:0] pc;
    logic        halted;

    logic [15:0] mem [0:65535];
    logic        mem_en;
    logic        ack_force;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] w;
    } exp_t;
    exp_t sb[$];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    assign imem_ack   = ack_force | (mem_en & imem_req);
    assign imem_rdata = ack_force ? 16'h8000 : mem[imem_addr];

    fetch_decode #(.RESET_PC(16'h0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .dec_valid  (dec_valid),
        .dec_ready  (dec_ready),
        .opp        (opp),
        .r1         (r1),
        .r2         (r2),
        .qr         (qr),
        .res        (res),
        .imm8       (imm8),
        .br_valid   (br_valid),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .pc         (pc),
        .halted     (halted)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [23:0] model(input logic [15:0] w);
        logic [4:0] op;
        op = w[15:11];
        if (op >= 5'd20) op = 5'd0;
        return {op, w[10:8], w[7:5], w[4:2], w[1:0], w[7:0]};
    endfunction

    function automatic logic [23:0] obs_fields();
        return {opp, r1, r2, qr, res, imm8};
    endfunction

    task automatic push(input logic [15:0] a, input logic [15:0] w);
        exp_t e;
        e.pc = a;
        e.w  = w;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && dec_valid && dec_ready) begin
            chk("sb_nonempty", {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("iss_pc", {16'b0, pc}, {16'b0, e.pc});
                chk("iss_fields", {8'b0, obs_fields()}, {8'b0, model(e.w)});
            end
        end
    end

    task automatic wait_req();
        int n;
        n = 0;
        while (!imem_req && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", {31'b0, imem_req}, 32'd1);
    endtask

    task automatic wait_hs(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(dec_valid && dec_ready) && n < 100);
        chk("hs_seen", {31'b0, dec_valid && dec_ready}, 32'd1);
    endtask

    task automatic do_br(input logic tk, input logic [15:0] tgt,
                         input logic [15:0] exp_addr);
        @(negedge clk);
        chk("wbr_idle", {30'b0, imem_req, dec_valid}, 32'd0);
        br_valid  = 1'b1;
        br_taken  = tk;
        br_target = tgt;
        @(negedge clk);
        br_valid = 1'b0;
        chk("br_addr", {16'b0, imem_addr}, {16'b0, exp_addr});
        chk("br_req", {31'b0, imem_req}, 32'd1);
    endtask

    initial begin
        int n;
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        mem[16'h0000] = 16'h0F25;
        mem[16'h0002] = 16'hCA34;
        mem[16'h0003] = 16'h6000;
        mem[16'h0005] = 16'h8000;
        mem[16'h0010] = 16'h7800;
        mem[16'h0011] = 16'h7800;
        mem[16'h0040] = 16'h1EE5;
        mem[16'h0041] = 16'h90AB;
        mem[16'h0042] = 16'h6000;
        rst_n = 1'b0;
        dec_ready = 1'b0;
        br_valid = 1'b0;
        br_taken = 1'b0;
        br_target = 16'h0000;
        mem_en = 1'b1;
        ack_force = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_pc", {16'b0, pc}, 32'd0);
        chk("rst_ctl", {29'b0, imem_req, dec_valid, halted}, 32'd0);
        chk("rst_fields", {8'b0, obs_fields()}, 32'd0);

        // stray branch inputs outside WAIT_BR must be ignored
        rst_n = 1'b1;
        dec_ready = 1'b1;
        br_valid = 1'b1;
        br_taken = 1'b1;
        br_target = 16'h0BAD;
        push(16'h0000, 16'h0F25);
        push(16'h0001, 16'h0000);
        push(16'h0002, 16'hCA34);
        push(16'h0003, 16'h6000);
        wait_req();
        chk("first_addr", {16'b0, imem_addr}, 32'd0);
        wait_hs(n);
        wait_hs(n);
        chk("thru_2cyc", n, 32'd2);
        br_valid = 1'b0;
        @(negedge clk);
        chk("seq_addr", {16'b0, imem_addr}, 32'h2);
        chk("seq_req", {31'b0, imem_req}, 32'd1);
        wait_hs(n);
        wait_hs(n);
        do_br(1'b0, 16'h0010, 16'h0010);

        push(16'h0010, 16'h7800);
        wait_hs(n);
        do_br(1'b0, 16'h0040, 16'h0011);
        push(16'h0011, 16'h7800);
        wait_hs(n);
        do_br(1'b1, 16'h0040, 16'h0040);
        dec_ready = 1'b0;

        n = 0;
        while (!dec_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (5) begin
            chk("stall_valid", {31'b0, dec_valid}, 32'd1);
            chk("stall_fields", {8'b0, obs_fields()}, {8'b0, model(16'h1EE5)});
            chk("stall_pc", {16'b0, pc}, 32'h40);
            @(negedge clk);
        end
        push(16'h0040, 16'h1EE5);
        push(16'h0041, 16'h90AB);
        push(16'h0042, 16'h6000);
        @(posedge clk);
        #1 dec_ready = 1'b1;
        wait_hs(n);
        wait_hs(n);
        wait_hs(n);
        do_br(1'b1, 16'hFFFF, 16'hFFFF);

        push(16'hFFFF, 16'h0000);
        wait_hs(n);
        @(negedge clk);
        chk("wrap_addr", {16'b0, imem_addr}, 32'd0);
        chk("wrap_req", {31'b0, imem_req}, 32'd1);
        push(16'h0000, 16'h0F25);
        push(16'h0001, 16'h0000);
        push(16'h0002, 16'hCA34);
        push(16'h0003, 16'h6000);
        repeat (4) wait_hs(n);
        do_br(1'b1, 16'h0005, 16'h0005);

        push(16'h0005, 16'h8000);
        wait_hs(n);
        @(negedge clk);
        chk("hlt_halted", {31'b0, halted}, 32'd1);
        chk("hlt_valid", {31'b0, dec_valid}, 32'd0);
        repeat (20) begin
            chk("hlt_noreq", {30'b0, imem_req, halted}, 32'd1);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_pc2", {16'b0, pc}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem[16'h0001] = 16'h8800;

        push(16'h0000, 16'h0F25);
        push(16'h0001, 16'h8800);
        wait_req();
        chk("resume_addr", {16'b0, imem_addr}, 32'd0);
        wait_hs(n);
        wait_hs(n);
        @(negedge clk);
        chk("rsti_addr", {16'b0, imem_addr}, 32'd0);
        chk("rsti_req", {31'b0, imem_req}, 32'd1);
        mem_en = 1'b0;
        @(negedge clk);
        chk("pend_req", {31'b0, imem_req}, 32'd1);
        rst_n = 1'b0;
        ack_force = 1'b1;
        #1;
        chk("midrst_ctl", {30'b0, imem_req, dec_valid}, 32'd0);
        @(negedge clk);
        push(16'h0000, 16'h0F25);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        ack_force = 1'b0;
        mem_en = 1'b1;
        wait_hs(n);
        @(posedge clk);
        #1 dec_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("end_halted", {31'b0, halted}, 32'd0);
        chk("sb_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_decode.md
# fetch_decode

Instruction fetch and decode stage of the 16-bit CPU, directly upstream of the control unit. It holds the program counter and fetches 16-bit instruction words over a request/acknowledge instruction-memory port. It splits each word into the opcode, register-select and result fields the control unit consumes, and issues them with a valid/ready handshake. It also resolves program flow: sequential increment, jump redirection from the control unit's branch result, halt and soft reset.

## Interface
Parameters:
- RESET_PC, 16'h0000, PC value after reset and after an RST instruction

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- imem_req  out  1  fetch request, held until acknowledged
- imem_addr  out  16  fetch address; always equals pc
- imem_ack  in  1  memory acknowledge; instruction is valid in the same cycle
- imem_rdata  in  16  instruction word
- dec_valid  out  1  decoded fields valid to control unit
- dec_ready  in  1  control unit accepts fields
- opp  out  5  opcode, instr[15:11]
- r1  out  3  source register 1, instr[10:8]
- r2  out  3  source register 2, instr[7:5]
- qr  out  3  destination register, instr[4:2]
- res  out  2  result/mode bits, instr[1:0]
- imm8  out  8  immediate for SETH/SETL, instr[7:0]
- br_valid  in  1  control unit branch resolution valid
- br_taken  in  1  jump condition met
- br_target  in  16  jump destination
- pc  out  16  current program counter
- halted  out  1  core halted by HLT

## Operation
- Opcodes:
  - 0 NOP
  - 1–10 ALU ops: ADD, ADC, SUB, SDC, SBB, AND, OR, XOR, NOT, SHFT
  - 11 MOV
  - 12 JMP, 13 JGO, 14 JLO, 15 JEO
  - 16 HLT
  - 17 RST
  - 18 SETH, 19 SETL
  - 20–31 reserved
- States:
  - BOOT: first cycle after reset; goes to FETCH.
  - FETCH: imem_req=1. On imem_req&&imem_ack, capture imem_rdata into the instruction register and go to ISSUE.
  - ISSUE: dec_valid=1; fields are driven from the instruction register and stay stable until dec_ready. On dec_valid&&dec_ready:
    - opcodes 12–15: go to WAIT_BR.
    - HLT: go to HALT.
    - RST: pc←RESET_PC, go to FETCH.
    - otherwise: pc←pc+1, go to FETCH.
  - WAIT_BR: br_valid is sampled only in this state. When br_valid=1:
    - pc←br_target if br_taken, or if opp==12 (unconditional; br_taken ignored)
    - else pc←pc+1
    - then go to FETCH
  - HALT: halted=1, no requests. Only rst_n leaves this state.
- Reserved opcodes 20–31 are issued with opp forced to 0 (NOP); the other fields pass through unchanged.
- PC arithmetic is modulo 2^16: 16'hFFFF+1 = 16'h0000.
- Ignored inputs:
  - imem_ack outside FETCH
  - dec_ready outside ISSUE
  - br_valid outside WAIT_BR

## Timing
- Reset values (asynchronous, immediate on rst_n low):
  - pc=RESET_PC
  - imem_req=0, dec_valid=0, halted=0
  - opp/r1/r2/qr/res/imm8=0
  - state=BOOT
- Reset mid-fetch or mid-issue: the in-flight instruction is discarded; a late imem_ack is ignored.
- Fetch may complete in the cycle imem_req first rises (zero-wait memory).
- Minimum throughput, zero-wait memory, dec_ready tied high:
  - non-jump instruction: 2 cycles (FETCH, ISSUE)
  - jump with br_valid in the first WAIT_BR cycle: 3 cycles
- The new pc is visible on pc/imem_addr in the cycle after the ISSUE handshake (or after br_valid); imem_req is high in that same cycle.
- All outputs are registered; no combinational path from any input to any output.

## Structure
- Shared package cpu_pkg holds:
  - opcode localparams OP_NOP…OP_SETL
  - field bit positions
  - the state enum
- The control unit imports cpu_pkg too, so opcode numbering has a single source.
- One sub-module: instr_split, a purely combinational field extractor with the reserved-opcode→NOP mapping. The FSM and PC stay in fetch_decode.

## Test plan
- Reset, zero-wait memory, dec_ready=1, imem_rdata=16'h0F25 (ADD r7,r1,qr1,res1) at addr 0:
  - imem_addr=0 first
  - ISSUE shows opp=1, r1=7, r2=1, qr=1, res=1
  - then imem_addr=1; one instruction per 2 cycles
- dec_ready held low 5 cycles in ISSUE: dec_valid and all fields stable; pc unchanged until the handshake.
- JEO (16'h7800) at pc=0x10:
  - br_valid=1, br_taken=0 → next fetch 0x11
  - repeat with br_taken=1, br_target=0x0040 → next fetch 0x40
  - JMP with br_taken=0 still goes to br_target
- HLT at pc=5: halted=1, imem_req stays 0 for 20 cycles; rst_n pulse → fetch resumes at RESET_PC.
- pc=16'hFFFF with a NOP → next imem_addr=16'h0000. Opcode 25 word → issued with opp=0.
- rst_n asserted while imem_req=1 with ack pending: imem_req drops immediately; after release, fetch restarts at RESET_PC and the stale ack is ignored.
